// File: rtl/case_follow_pkg.sv
// Shared constants and helpers for the case-follow decode pipeline.
// Decoded lane width is derived from the selector width in one place.
package case_follow_pkg;

  localparam logic [3:0] DEFAULT_EMPTY_MASK = 4'b0001;

  function automatic int out_w_of(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/case_lane_dec.sv
// Single-lane decoder: one-hot for ordinary codes, zero or held value for
// codes marked empty in the mask.
module case_lane_dec
  import case_follow_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int OUT_W      = out_w_of(SEL_W),
  parameter int HOLD_EMPTY = 0
) (
  input  logic [SEL_W-1:0] code,
  input  logic [OUT_W-1:0] mask,
  input  logic [OUT_W-1:0] hold,
  output logic [OUT_W-1:0] vec,
  output logic             empty
);

  always_comb begin
    vec   = '0;
    empty = 1'b0;
    case (mask[code])
      1'b1: begin
        empty = 1'b1;
        if (HOLD_EMPTY != 0) vec = hold;
      end
      default: vec[code] = 1'b1;
    endcase
  end

endmodule

// File: rtl/case_follow_pipe.sv
// Two-stage valid/ready pipe: S1 captures raw selectors, S2 holds the
// per-lane decoded vectors plus a saturating count of empty-code hits.
module case_follow_pipe
  import case_follow_pkg::*;
#(
  parameter int                          SEL_W      = 2,
  parameter int                          LANES      = 2,
  parameter logic [out_w_of(SEL_W)-1:0]  EMPTY_MASK = DEFAULT_EMPTY_MASK,
  parameter int                          HOLD_EMPTY = 0,
  parameter int                          CNT_W      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*SEL_W-1:0]               in_sel,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*out_w_of(SEL_W)-1:0]     out_dec,
  input  logic                                 clr_cnt,
  output logic [CNT_W-1:0]                     empty_cnt
);

  localparam int OUT_W = out_w_of(SEL_W);

  logic                     s1_valid;
  logic [LANES*SEL_W-1:0]   s1_sel;
  logic                     s1_adv;
  logic [LANES*OUT_W-1:0]   dec_next;
  logic [LANES-1:0]         lane_empty;
  logic [CNT_W-1:0]         cnt_next;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;

  // Hold value is the S2 register itself, so held lanes follow the last load.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    case_lane_dec #(
      .SEL_W      (SEL_W),
      .OUT_W      (OUT_W),
      .HOLD_EMPTY (HOLD_EMPTY)
    ) u_dec (
      .code  (s1_sel[i*SEL_W +: SEL_W]),
      .mask  (EMPTY_MASK),
      .hold  (out_dec[i*OUT_W +: OUT_W]),
      .vec   (dec_next[i*OUT_W +: OUT_W]),
      .empty (lane_empty[i])
    );
  end

  always_comb begin
    cnt_next = empty_cnt;
    if (s1_adv) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_empty[i] && (cnt_next != {CNT_W{1'b1}})) cnt_next = cnt_next + 1'b1;
      end
    end
    if (clr_cnt) cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_sel   <= in_sel;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // out_dec keeps its value after the word leaves so held lanes still see it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_dec   <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_dec   <= dec_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) empty_cnt <= '0;
    else        empty_cnt <= cnt_next;
  end

endmodule

// File: tb/tb_case_follow_pipe.sv
// Bench for case_follow_pipe: one zeroing and one holding instance share the
// stimulus and are checked against an in-order word model every cycle.
module tb_case_follow_pipe;

  localparam logic [3:0] MASK = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_sel;
  logic       out_ready;
  logic       clr_cnt;

  logic       ir0, ir1, ov0, ov1;
  logic [7:0] od0, od1;
  logic [3:0] ec0, ec1;

  int n_cmp = 0;
  int n_bad = 0;
  longint edge_cnt = 0;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    int         cnt;
    longint     edge_n;
  } exp_t;

  exp_t       q[$];
  logic [7:0] prev0, prev1;
  int         acc;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  case_follow_pipe #(.SEL_W(2), .LANES(2), .EMPTY_MASK(MASK), .HOLD_EMPTY(0), .CNT_W(4)) dut_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_sel(in_sel),
    .out_valid(ov0), .out_ready(out_ready), .out_dec(od0), .clr_cnt(clr_cnt), .empty_cnt(ec0)
  );

  case_follow_pipe #(.SEL_W(2), .LANES(2), .EMPTY_MASK(MASK), .HOLD_EMPTY(1), .CNT_W(4)) dut_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_sel(in_sel),
    .out_valid(ov1), .out_ready(out_ready), .out_dec(od1), .clr_cnt(clr_cnt), .empty_cnt(ec1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: words leave in acceptance order; a word is visible one edge
  // after it was accepted; decode follows the code/mask rules directly.
  always @(negedge clk) begin
    int         occ;
    logic       exp_ready, exp_ov;
    exp_t       e;
    int         c;
    logic [3:0] v0, v1;
    if (!rst_n) begin
      q.delete();
      prev0 = '0;
      prev1 = '0;
      acc   = 0;
    end else begin
      occ       = q.size();
      exp_ready = (occ < 2) || out_ready;
      chk("in_ready_zero", ir0, exp_ready);
      chk("in_ready_hold", ir1, exp_ready);
      exp_ov = (occ > 0) && (edge_cnt >= q[0].edge_n + 1);
      chk("out_valid_zero", ov0, exp_ov);
      chk("out_valid_hold", ov1, exp_ov);
      if (exp_ov) begin
        chk("out_dec_zero", od0, q[0].d0);
        chk("out_dec_hold", od1, q[0].d1);
        chk("empty_cnt_zero", ec0, q[0].cnt);
        chk("empty_cnt_hold", ec1, q[0].cnt);
        if (out_ready) void'(q.pop_front());
      end
      if (clr_cnt) acc = 0;
      if (in_valid && exp_ready) begin
        e.edge_n = edge_cnt + 1;
        for (int i = 0; i < 2; i++) begin
          c = int'(in_sel[i*2 +: 2]);
          if (MASK[c]) begin
            v0 = 4'b0000;
            v1 = prev1[i*4 +: 4];
            if (!clr_cnt && acc < 15) acc = acc + 1;
          end else begin
            v0 = 4'b0001 << c;
            v1 = v0;
          end
          e.d0[i*4 +: 4] = v0;
          e.d1[i*4 +: 4] = v1;
        end
        e.cnt = acc;
        prev0 = e.d0;
        prev1 = e.d1;
        q.push_back(e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_out_dec", od1, 8'h00);
    rst_n = 1'b1;

    // Latency and a plain one-hot word
    in_valid = 1'b1; in_sel = 4'b1001;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", ov0, 1'b0);
    tick();
    @(negedge clk);
    chk("lat_valid", ov0, 1'b1);
    chk("dec_1001", od0, 8'b0100_0010);
    chk("cnt_unchanged", ec0, 4'd0);

    // Empty code after code 3 on lane 0
    tick();
    in_valid = 1'b1; in_sel = 4'b0111;
    tick();
    in_sel = 4'b0100;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_zero", od0, 8'b0010_1000);
    chk("first_hold_lane0", od1[3:0], 4'b1000);
    tick();
    @(negedge clk);
    chk("empty_zero_dec", od0, 8'b0010_0000);
    chk("empty_hold_dec", od1, 8'b0010_1000);
    chk("empty_zero_cnt", ec0, 4'd1);
    chk("empty_hold_cnt", ec1, 4'd1);

    // Backpressure: two words fill the pipe, third waits
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 4'b0110;
    tick();
    in_sel = 4'b1011;
    tick();
    in_sel = 4'b1110;
    @(negedge clk);
    chk("bp_ready_low", ir0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_stable_dec", od0, 8'b0010_0100);
    chk("bp_stable_valid", ov1, 1'b1);
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_sel    = 4'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Saturation, then clear racing an empty word
    in_valid = 1'b1; in_sel = 4'b0000;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("sat_zero", ec0, 4'd15);
    chk("sat_hold", ec1, 4'd15);
    tick();
    clr_cnt = 1'b1; in_valid = 1'b1; in_sel = 4'b0000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_zero", ec0, 4'd0);
    chk("clr_hold", ec1, 4'd0);

    // Asynchronous reset with both stages full
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'b0000;
    tick();
    in_sel = 4'b1100;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_zero", ov0, 1'b0);
    chk("arst_valid_hold", ov1, 1'b0);
    chk("arst_dec_hold", od1, 8'h00);
    chk("arst_cnt_zero", ec0, 4'd0);
    repeat (2) tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_ready", ir0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_sel    = 4'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/case_follow_pipe.md
CASE_FOLLOW_PIPE -- requirements
Module: case_follow_pipe

Interface
REQ-001 Parameter SEL_W, default 2, selector width per lane; decoded width per lane is OUT_W = 2**SEL_W.
REQ-002 Parameter LANES, default 2, number of independent selector lanes sharing one handshake.
REQ-003 Parameter EMPTY_MASK, default 4'b0001, OUT_W bits; bit k=1 marks code k as an empty case item that asserts no output bit.
REQ-004 Parameter HOLD_EMPTY, default 0; 0 = empty code drives the lane to all-zero, 1 = empty code holds the lane's previous output.
REQ-005 Parameter CNT_W, default 4, width of the empty-hit counter.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 in_valid  input  1  input word valid.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 in_sel  input  LANES*SEL_W  lane i selector at bits [i*SEL_W +: SEL_W].
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  consumer accepts output this cycle.
REQ-013 out_dec  output  LANES*OUT_W  lane i decoded vector at bits [i*OUT_W +: OUT_W].
REQ-014 clr_cnt  input  1  synchronous clear of empty_cnt.
REQ-015 empty_cnt  output  CNT_W  saturating count of empty-code lane hits.

Function
REQ-016 Two register stages: S1 captures in_sel; S2 holds decoded out_dec and out_valid.
REQ-017 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-018 S1 advances into S2 when S1 is valid and (S2 empty or out_ready=1).
REQ-019 in_ready = (S1 empty) or (S1 advancing this cycle); the path is combinational, with no dependency on in_valid.
REQ-020 Latency is 2 cycles from input transfer to out_valid=1 while out_ready is held 1; throughput is 1 word per cycle.
REQ-021 With out_ready=0, S2 and S1 both fill; then in_ready=0, and out_dec and out_valid stay stable until the transfer.
REQ-022 Per-lane decode for code c with EMPTY_MASK[c]=0: the lane vector is one-hot, with only bit c set.
REQ-023 Per-lane decode for code c with EMPTY_MASK[c]=1 and HOLD_EMPTY=0: the lane vector is all zeros.
REQ-024 Per-lane decode for code c with EMPTY_MASK[c]=1 and HOLD_EMPTY=1: the lane vector equals that lane's current S2 value, i.e. the last value loaded into S2.
REQ-025 Lanes decode independently; an empty code on one lane does not affect other lanes.
REQ-026 On each S1->S2 advance, empty_cnt increments by the number of lanes carrying an empty code, saturating at 2**CNT_W-1.
REQ-027 clr_cnt=1 sets empty_cnt to 0 at the next edge; clear wins over a simultaneous increment.
REQ-028 An all-zero EMPTY_MASK is legal; empty_cnt then never changes.

Reset
REQ-029 While rst_n=0: S1 valid=0, out_valid=0, out_dec=0 and empty_cnt=0, asynchronously.
REQ-030 in_ready=1 from the first edge after rst_n rises.
REQ-031 Reset mid-transfer discards all in-flight words; HOLD_EMPTY history restarts from zero.

Structure
REQ-032 Package case_follow_pkg holds the OUT_W derivation function and the default EMPTY_MASK constant.
REQ-033 One sub-module, case_lane_dec, decodes a single lane (code, mask, hold value -> vector, empty flag) and is instantiated LANES times.
REQ-034 No latches are permitted; every combinational decode path assigns a default before the case statement, including for empty items.

Verification
REQ-035 Use the default parameters and out_ready=1; send in_sel=4'b1001 (lane1=2, lane0=1) -> two cycles later out_dec=8'b0100_0010 and empty_cnt unchanged.
REQ-036 HOLD_EMPTY=0: send lane0=0 after lane0=3 -> lane0 vector=4'b0000 and empty_cnt increments by 1.
REQ-037 HOLD_EMPTY=1: send lane0=3 then lane0=0 -> lane0 vector stays 4'b1000 on both outputs and empty_cnt=1.
REQ-038 Backpressure: out_ready=0 while sending 3 words -> in_ready drops after 2 words and out_dec is stable; then out_ready=1 -> words emerge in order with none lost.
REQ-039 Saturation and clear: 20 words with both lanes at code 0 (CNT_W=4) -> empty_cnt=15; assert clr_cnt together with another empty word -> empty_cnt=0.
REQ-040 Drop rst_n while S1 and S2 are full -> out_valid=0, out_dec=0 and empty_cnt=0 immediately, without waiting for a clock edge.
